// File: rtl/urt_rx_pkg.sv
// ---------------------------------------------------------------------------
// urt_rx_pkg
// Shared definitions for the UART RX sequencer: the frame state encoding,
// the legal oversampling ratios, the data-bit count and helpers that derive
// the in-bit sample and check positions from the latched prescale.
// ---------------------------------------------------------------------------
package urt_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int PRESC_W = 6;

  localparam logic [PRESC_W-1:0] PRESC_8  = 6'd8;
  localparam logic [PRESC_W-1:0] PRESC_16 = 6'd16;
  localparam logic [PRESC_W-1:0] PRESC_32 = 6'd32;

  localparam logic [3:0] DATA_BITS = 4'd8;

  // Middle of the bit: the sampler votes at SAMP-1, SAMP, SAMP+1.
  function automatic logic [PRESC_W-1:0] samp_of(input logic [PRESC_W-1:0] p);
    return {1'b0, p[PRESC_W-1:1]};
  endfunction

  // Checks fire two edges after the middle so the vote has settled.
  function automatic logic [PRESC_W-1:0] chk_of(input logic [PRESC_W-1:0] p);
    return samp_of(p) + 6'd2;
  endfunction

  function automatic logic presc_legal(input logic [PRESC_W-1:0] p);
    return (p == PRESC_8) || (p == PRESC_16) || (p == PRESC_32);
  endfunction

endpackage

// File: rtl/urt_rx_edge_bit_cnt.sv
// ---------------------------------------------------------------------------
// urt_rx_edge_bit_cnt
// Edge counter (position inside a bit, 0..prescale-1) and bit counter
// (bit index in the frame). The bit counter advances when the edge counter
// wraps. All state decode lives in the FSM.
//
// Ports:
//   CLK_CNT    clock
//   RST_CNT    synchronous active-high reset
//   cnt_en     count this cycle
//   cnt_clr    force both counters to zero (wins over cnt_en)
//   prescale   latched oversampling ratio
//   edge_cnt   position inside the current bit
//   bit_cnt    bit index within the frame
//   last_edge  edge_cnt is at prescale-1 (wrap point)
// ---------------------------------------------------------------------------
module urt_rx_edge_bit_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             CLK_CNT,
  input  logic             RST_CNT,
  input  logic             cnt_en,
  input  logic             cnt_clr,
  input  logic [CNT_W-1:0] prescale,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [3:0]       bit_cnt,
  output logic             last_edge
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] edge_cnt_r;
  logic [3:0]       bit_cnt_r;

  assign last_edge = (edge_cnt_r == (prescale - CNT_ONE));
  assign edge_cnt  = edge_cnt_r;
  assign bit_cnt   = bit_cnt_r;

  // Edge/bit counter pair with clear priority over counting.
  always_ff @(posedge CLK_CNT) begin
    if (RST_CNT) begin
      edge_cnt_r <= CNT_ZERO;
      bit_cnt_r  <= 4'd0;
    end else if (cnt_clr) begin
      edge_cnt_r <= CNT_ZERO;
      bit_cnt_r  <= 4'd0;
    end else if (cnt_en) begin
      if (last_edge) begin
        edge_cnt_r <= CNT_ZERO;
        bit_cnt_r  <= bit_cnt_r + 4'd1;
      end else begin
        edge_cnt_r <= edge_cnt_r + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/urt_rx_fsm.sv
// ---------------------------------------------------------------------------
// urt_rx_fsm
// UART RX sequencer. Detects the start edge, runs the oversampling edge and
// bit counters, fires single-cycle enables to the sampler, deserializer and
// start/parity/stop checkers, and ends each frame with a data_valid or a
// frame_err pulse. STOP is left early (one edge after its check) so a start
// edge immediately following the stop bit is not missed.
//
// Ports:
//   CLK_FSM, RST_FSM        clock, synchronous active-high reset
//   RX_IN_FSM               synchronized serial line (idle high)
//   PAR_EN_FSM              frame carries a parity bit (latched at start)
//   PRESCALE_FSM            oversampling ratio 8/16/32 (latched at start)
//   strt_glitch_FSM         start checker failure (registered)
//   par_err_FSM             parity checker error (registered)
//   stp_err_FSM             stop checker error (registered)
//   edge_cnt_FSM            position inside current bit
//   bit_cnt_FSM             bit index: start=0, data=1..8, parity=9
//   dat_samp_en_FSM         sampler enable, high outside IDLE
//   deser_en_FSM            shift pulse per data bit
//   strt_chk_en_FSM         start-check pulse
//   par_chk_en_FSM          parity-check pulse
//   stp_chk_en_FSM          stop-check pulse
//   data_valid_FSM          frame accepted pulse
//   frame_err_FSM           frame rejected pulse
// ---------------------------------------------------------------------------
module urt_rx_fsm
  import urt_rx_pkg::*;
#(
  parameter logic [PRESC_W-1:0] DEF_PRESCALE = 6'd8,
  parameter int                 CNT_W        = 6
) (
  input  logic             CLK_FSM,
  input  logic             RST_FSM,
  input  logic             RX_IN_FSM,
  input  logic             PAR_EN_FSM,
  input  logic [5:0]       PRESCALE_FSM,
  input  logic             strt_glitch_FSM,
  input  logic             par_err_FSM,
  input  logic             stp_err_FSM,
  output logic [CNT_W-1:0] edge_cnt_FSM,
  output logic [3:0]       bit_cnt_FSM,
  output logic             dat_samp_en_FSM,
  output logic             deser_en_FSM,
  output logic             strt_chk_en_FSM,
  output logic             par_chk_en_FSM,
  output logic             stp_chk_en_FSM,
  output logic             data_valid_FSM,
  output logic             frame_err_FSM
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  rx_state_e          state_r;
  rx_state_e          next_state_s;
  logic [PRESC_W-1:0] presc_r;
  logic               par_en_r;
  logic [PRESC_W-1:0] presc_sel_s;

  logic [CNT_W-1:0]   edge_s;
  logic [3:0]         bit_s;
  logic               last_edge_s;
  logic               cnt_en_s;
  logic               cnt_clr_s;

  logic [CNT_W-1:0]   presc_cnt_s;
  logic [CNT_W-1:0]   chk_s;
  logic               pre_chk_s;
  logic               stop_exit_s;
  logic               frame_bad_s;

  logic dat_samp_en_r, deser_en_r, strt_chk_en_r, par_chk_en_r, stp_chk_en_r;
  logic data_valid_r, frame_err_r;

  assign presc_sel_s = presc_legal(PRESCALE_FSM) ? PRESCALE_FSM : DEF_PRESCALE;
  assign presc_cnt_s = CNT_W'(presc_r);
  assign chk_s       = CNT_W'(chk_of(presc_r));

  // Enables are registered, so decode one edge ahead; the state cannot change
  // between CHK-1 and CHK because transitions only happen at CHK+1 or P-1.
  assign pre_chk_s   = (edge_s == (chk_s - CNT_ONE));
  assign stop_exit_s = (state_r == STOP) && (edge_s == (chk_s + CNT_ONE));
  assign frame_bad_s = stp_err_FSM | (par_en_r & par_err_FSM);

  assign cnt_en_s  = (state_r != IDLE);
  assign cnt_clr_s = (state_r == IDLE) || (next_state_s == IDLE);

  urt_rx_edge_bit_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .CLK_CNT   (CLK_FSM),
    .RST_CNT   (RST_FSM),
    .cnt_en    (cnt_en_s),
    .cnt_clr   (cnt_clr_s),
    .prescale  (presc_cnt_s),
    .edge_cnt  (edge_s),
    .bit_cnt   (bit_s),
    .last_edge (last_edge_s)
  );

  // Next-state decode for the frame sequencer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!RX_IN_FSM) begin
          next_state_s = START;
        end else begin
          next_state_s = IDLE;
        end
      end
      START: begin
        if (last_edge_s) begin
          next_state_s = strt_glitch_FSM ? IDLE : DATA;
        end else begin
          next_state_s = START;
        end
      end
      DATA: begin
        if (last_edge_s && (bit_s == DATA_BITS)) begin
          next_state_s = par_en_r ? PARITY : STOP;
        end else begin
          next_state_s = DATA;
        end
      end
      PARITY: begin
        if (last_edge_s) begin
          next_state_s = STOP;
        end else begin
          next_state_s = PARITY;
        end
      end
      STOP: begin
        if (stop_exit_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = STOP;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, latched frame config and registered enables/pulses.
  always_ff @(posedge CLK_FSM) begin
    if (RST_FSM) begin
      state_r       <= IDLE;
      presc_r       <= DEF_PRESCALE;
      par_en_r      <= 1'b0;
      dat_samp_en_r <= 1'b0;
      deser_en_r    <= 1'b0;
      strt_chk_en_r <= 1'b0;
      par_chk_en_r  <= 1'b0;
      stp_chk_en_r  <= 1'b0;
      data_valid_r  <= 1'b0;
      frame_err_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if ((state_r == IDLE) && (next_state_s == START)) begin
        presc_r  <= presc_sel_s;
        par_en_r <= PAR_EN_FSM;
      end
      dat_samp_en_r <= (next_state_s != IDLE);
      strt_chk_en_r <= (state_r == START)  && pre_chk_s;
      deser_en_r    <= (state_r == DATA)   && pre_chk_s;
      par_chk_en_r  <= (state_r == PARITY) && pre_chk_s;
      stp_chk_en_r  <= (state_r == STOP)   && pre_chk_s;
      data_valid_r  <= stop_exit_s && !frame_bad_s;
      frame_err_r   <= stop_exit_s && frame_bad_s;
    end
  end

  assign edge_cnt_FSM    = edge_s;
  assign bit_cnt_FSM     = bit_s;
  assign dat_samp_en_FSM = dat_samp_en_r;
  assign deser_en_FSM    = deser_en_r;
  assign strt_chk_en_FSM = strt_chk_en_r;
  assign par_chk_en_FSM  = par_chk_en_r;
  assign stp_chk_en_FSM  = stp_chk_en_r;
  assign data_valid_FSM  = data_valid_r;
  assign frame_err_FSM   = frame_err_r;

endmodule

// File: tb/tb_urt_rx_fsm.sv
// ---------------------------------------------------------------------------
// tb_urt_rx_fsm
// Directed frames for the UART RX sequencer. The stimulus thread queues the
// expected end-of-frame pulse (kind, cycle, parity-check count); a monitor
// thread pops and compares whenever data_valid or frame_err appears, and
// checks enable placement within each bit.
// ---------------------------------------------------------------------------
module tb_urt_rx_fsm;

  localparam int CNT_W = 6;

  logic             CLK_FSM = 1'b0;
  logic             RST_FSM = 1'b1;
  logic             RX_IN_FSM = 1'b1;
  logic             PAR_EN_FSM = 1'b0;
  logic [5:0]       PRESCALE_FSM = 6'd8;
  logic             strt_glitch_FSM = 1'b0;
  logic             par_err_FSM = 1'b0;
  logic             stp_err_FSM = 1'b0;
  logic [CNT_W-1:0] edge_cnt_FSM;
  logic [3:0]       bit_cnt_FSM;
  logic             dat_samp_en_FSM, deser_en_FSM, strt_chk_en_FSM;
  logic             par_chk_en_FSM, stp_chk_en_FSM, data_valid_FSM, frame_err_FSM;

  urt_rx_fsm #(.DEF_PRESCALE(6'd8), .CNT_W(CNT_W)) dut (
    .CLK_FSM         (CLK_FSM),
    .RST_FSM         (RST_FSM),
    .RX_IN_FSM       (RX_IN_FSM),
    .PAR_EN_FSM      (PAR_EN_FSM),
    .PRESCALE_FSM    (PRESCALE_FSM),
    .strt_glitch_FSM (strt_glitch_FSM),
    .par_err_FSM     (par_err_FSM),
    .stp_err_FSM     (stp_err_FSM),
    .edge_cnt_FSM    (edge_cnt_FSM),
    .bit_cnt_FSM     (bit_cnt_FSM),
    .dat_samp_en_FSM (dat_samp_en_FSM),
    .deser_en_FSM    (deser_en_FSM),
    .strt_chk_en_FSM (strt_chk_en_FSM),
    .par_chk_en_FSM  (par_chk_en_FSM),
    .stp_chk_en_FSM  (stp_chk_en_FSM),
    .data_valid_FSM  (data_valid_FSM),
    .frame_err_FSM   (frame_err_FSM)
  );

  always #5 CLK_FSM = ~CLK_FSM;

  int cyc = 0;
  always @(posedge CLK_FSM) cyc <= cyc + 1;

  // Checker models: each flag is registered one cycle after its enable.
  logic cfg_glitch = 1'b0, cfg_par_err = 1'b0, cfg_stp_err = 1'b0;
  always @(posedge CLK_FSM) begin
    if (RST_FSM) begin
      strt_glitch_FSM <= 1'b0;
      par_err_FSM     <= 1'b0;
      stp_err_FSM     <= 1'b0;
    end else begin
      if (strt_chk_en_FSM) strt_glitch_FSM <= cfg_glitch;
      if (par_chk_en_FSM)  par_err_FSM     <= cfg_par_err;
      if (stp_chk_en_FSM)  stp_err_FSM     <= cfg_stp_err;
    end
  end

  typedef struct {
    string name;
    bit    is_err;
    int    cyc;
    int    n_par;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cur_chk = 6;
  int   deser_cnt = 0, par_cnt = 0, strt_cnt = 0, stp_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK_FSM);
    #1;
  endtask

  // One frame: start bit, 8 data bits LSB first, optional even parity, stop.
  // PRESCALE/PAR_EN are disturbed after the start bit to prove they are latched.
  task automatic send_frame(input string nm, input logic [5:0] p_cfg, input logic [5:0] p_mid,
                            input int p_eff, input bit pen, input logic [7:0] data,
                            input bit perr, input bit serr, input int chk, input int off,
                            input bit exp_err, input int gap);
    int   t0;
    exp_t e;
    t0           = cyc;
    PRESCALE_FSM = p_cfg;
    PAR_EN_FSM   = pen;
    cfg_glitch   = 1'b0;
    cfg_par_err  = perr;
    cfg_stp_err  = serr;
    cur_chk      = chk;
    e.name   = nm;
    e.is_err = exp_err;
    e.cyc    = t0 + off;
    e.n_par  = pen ? 1 : 0;
    exp_q.push_back(e);
    RX_IN_FSM = 1'b0;
    repeat (p_eff) tick();
    PRESCALE_FSM = p_mid;
    PAR_EN_FSM   = ~pen;
    for (int i = 0; i < 8; i++) begin
      RX_IN_FSM = data[i];
      repeat (p_eff) tick();
    end
    if (pen) begin
      RX_IN_FSM = ^data;
      repeat (p_eff) tick();
    end
    RX_IN_FSM = 1'b1;
    while (cyc < t0 + off) tick();
    check({nm, "_idle_samp_en"}, {31'd0, dat_samp_en_FSM}, 32'd0);
    check({nm, "_idle_edge"}, {26'd0, edge_cnt_FSM}, 32'd0);
    while (cyc < t0 + off + gap) tick();
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    fork
      begin : stimulus
        int t0;
        int budget;
        repeat (3) tick();
        check("reset_outputs", {25'd0, dat_samp_en_FSM, deser_en_FSM, strt_chk_en_FSM,
              par_chk_en_FSM, stp_chk_en_FSM, data_valid_FSM, frame_err_FSM}, 32'd0);
        check("reset_edge", {26'd0, edge_cnt_FSM}, 32'd0);
        check("reset_bit", {28'd0, bit_cnt_FSM}, 32'd0);
        RST_FSM = 1'b0;
        repeat (2) tick();

        //          name          cfg     mid     Peff pen data  perr serr chk off  err gap
        send_frame("p8_nopar",    6'd8,  6'd8,  8,  0, 8'hA5, 0, 0, 6,  81,  0, 4);
        send_frame("p8_par",      6'd8,  6'd8,  8,  1, 8'hA5, 0, 0, 6,  89,  0, 4);
        send_frame("p16_par_err", 6'd16, 6'd16, 16, 1, 8'h3C, 1, 0, 10, 173, 1, 4);
        send_frame("p8_stop_err", 6'd8,  6'd8,  8,  0, 8'h5A, 0, 1, 6,  81,  1, 4);
        send_frame("p8_par_mask", 6'd8,  6'd8,  8,  0, 8'hFF, 1, 0, 6,  81,  0, 4);
        send_frame("p32_par",     6'd32, 6'd32, 32, 1, 8'h81, 0, 0, 18, 341, 0, 4);

        // Short start pulse rejected by the start checker.
        t0           = cyc;
        cfg_glitch   = 1'b1;
        PRESCALE_FSM = 6'd8;
        PAR_EN_FSM   = 1'b0;
        cur_chk      = 6;
        RX_IN_FSM    = 1'b0;
        repeat (2) tick();
        RX_IN_FSM = 1'b1;
        while (cyc < t0 + 8) tick();
        check("glitch_in_start_samp", {31'd0, dat_samp_en_FSM}, 32'd1);
        check("glitch_in_start_edge", {26'd0, edge_cnt_FSM}, 32'd7);
        tick();
        check("glitch_idle_samp", {31'd0, dat_samp_en_FSM}, 32'd0);
        check("glitch_idle_edge", {26'd0, edge_cnt_FSM}, 32'd0);
        check("glitch_idle_bit", {28'd0, bit_cnt_FSM}, 32'd0);
        repeat (20) tick();
        check("glitch_no_deser", deser_cnt, 32'd0);
        cfg_glitch = 1'b0;

        // Reset in the middle of the data bits abandons the frame.
        RX_IN_FSM = 1'b0;
        tick();
        RX_IN_FSM = 1'b1;
        budget = 0;
        while ((bit_cnt_FSM != 4'd4) && (budget < 200)) begin
          tick();
          budget++;
        end
        check("rst_mid_reach_bit4", {28'd0, bit_cnt_FSM}, 32'd4);
        RST_FSM = 1'b1;
        tick();
        check("rst_mid_outputs", {25'd0, dat_samp_en_FSM, deser_en_FSM, strt_chk_en_FSM,
              par_chk_en_FSM, stp_chk_en_FSM, data_valid_FSM, frame_err_FSM}, 32'd0);
        check("rst_mid_edge", {26'd0, edge_cnt_FSM}, 32'd0);
        check("rst_mid_bit", {28'd0, bit_cnt_FSM}, 32'd0);
        RST_FSM = 1'b0;
        repeat (120) tick();
        check("rst_mid_no_deser", deser_cnt, 32'd0);

        // Illegal prescale falls back to 8; second frame starts in the pulse cycle.
        send_frame("p12_b2b_a",   6'd12, 6'd32, 8,  0, 8'hC3, 0, 0, 6,  81,  0, 0);
        send_frame("p12_b2b_b",   6'd12, 6'd32, 8,  0, 8'h0F, 0, 0, 6,  81,  0, 6);

        check("scoreboard_drained", exp_q.size(), 32'd0);
      end
      begin : monitor
        forever begin
          @(negedge CLK_FSM);
          if (RST_FSM) begin
            deser_cnt = 0;
            par_cnt   = 0;
            strt_cnt  = 0;
            stp_cnt   = 0;
          end else begin
            if (strt_chk_en_FSM | deser_en_FSM | par_chk_en_FSM | stp_chk_en_FSM)
              check("enable_onehot", $countones({strt_chk_en_FSM, deser_en_FSM,
                    par_chk_en_FSM, stp_chk_en_FSM}), 32'd1);
            if (strt_chk_en_FSM) begin
              strt_cnt++;
              check("strt_edge", {26'd0, edge_cnt_FSM}, cur_chk);
              check("strt_bit", {28'd0, bit_cnt_FSM}, 32'd0);
            end
            if (deser_en_FSM) begin
              deser_cnt++;
              check("deser_edge", {26'd0, edge_cnt_FSM}, cur_chk);
              check("deser_bit", {28'd0, bit_cnt_FSM}, deser_cnt);
            end
            if (par_chk_en_FSM) begin
              par_cnt++;
              check("par_edge", {26'd0, edge_cnt_FSM}, cur_chk);
              check("par_bit", {28'd0, bit_cnt_FSM}, 32'd9);
            end
            if (stp_chk_en_FSM) begin
              stp_cnt++;
              check("stp_edge", {26'd0, edge_cnt_FSM}, cur_chk);
            end
            if (data_valid_FSM | frame_err_FSM) begin
              check("pulse_exclusive", {31'd0, data_valid_FSM & frame_err_FSM}, 32'd0);
              check("pulse_expected", {31'd0, exp_q.size() > 0}, 32'd1);
              if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "_kind_err"}, {31'd0, frame_err_FSM}, {31'd0, mon_e.is_err});
                check({mon_e.name, "_pulse_cycle"}, cyc, mon_e.cyc);
                check({mon_e.name, "_deser_count"}, deser_cnt, 32'd8);
                check({mon_e.name, "_par_count"}, par_cnt, mon_e.n_par);
                check({mon_e.name, "_strt_count"}, strt_cnt, 32'd1);
                check({mon_e.name, "_stp_count"}, stp_cnt, 32'd1);
              end
              deser_cnt = 0;
              par_cnt   = 0;
              strt_cnt  = 0;
              stp_cnt   = 0;
            end
          end
        end
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/urt_rx_fsm.md
Name: urt_rx_fsm

Overview:
Receive-side sequencer for the UART RX path. It detects the start edge and runs the oversampling edge counter and bit counter. It issues single-cycle enables to the data sampler, deserializer, start checker, parity checker and stop checker. At the end of each frame it reports either data_valid or a frame error. It sits between the RX pin synchronizer and the existing RX checker/deserializer blocks, which register their error flags one cycle after their enable.

Parameters:
DEF_PRESCALE, 8, prescale used when PRESCALE_FSM holds an unsupported value
CNT_W, 6, edge counter width (covers prescale 32)

Ports:
CLK_FSM  input  1  block clock, oversampled bit clock domain
RST_FSM  input  1  synchronous, active-high reset
RX_IN_FSM  input  1  synchronized serial line, idle high
PAR_EN_FSM  input  1  1 = frame carries a parity bit
PRESCALE_FSM  input  6  oversampling ratio: 8, 16 or 32
strt_glitch_FSM  input  1  registered start-check failure from start checker
par_err_FSM  input  1  registered parity error from parity checker
stp_err_FSM  input  1  registered stop error from stop checker
edge_cnt_FSM  output  CNT_W  position inside current bit, 0..prescale-1
bit_cnt_FSM  output  4  bit index in frame: start=0, data=1..8, parity=9
dat_samp_en_FSM  output  1  sampler enable, high in every non-IDLE state
deser_en_FSM  output  1  one-cycle shift pulse per data bit
strt_chk_en_FSM  output  1  one-cycle start-check pulse
par_chk_en_FSM  output  1  one-cycle parity-check pulse
stp_chk_en_FSM  output  1  one-cycle stop-check pulse
data_valid_FSM  output  1  one-cycle pulse, frame accepted
frame_err_FSM  output  1  one-cycle pulse, frame rejected on parity or stop error

Behaviour:
- Reset (sync, RST_FSM=1 at a rising edge): state is IDLE, edge_cnt=0, bit_cnt=0, all enables and pulses 0. Applies mid-frame too: the frame is abandoned with no data_valid or frame_err.
- Latched config: PAR_EN_FSM and PRESCALE_FSM are captured on IDLE->START and held for the whole frame.
  - Latched prescale P is PRESCALE_FSM if it equals 8, 16 or 32; otherwise P = DEF_PRESCALE.
- Derived points: SAMP = P/2; CHK = SAMP+2; the sampler votes at SAMP-1, SAMP and SAMP+1.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: counters held at 0. RX_IN_FSM=0 -> START, and START's first cycle has edge_cnt=0.
- Counting outside IDLE:
  - edge_cnt increments every cycle and wraps P-1 -> 0.
  - bit_cnt increments on each edge_cnt wrap.
- Check pulses at edge_cnt==CHK, one per bit:
  - START: strt_chk_en=1.
  - DATA: deser_en=1.
  - PARITY: par_chk_en=1.
  - STOP: stp_chk_en=1.
- Transitions at edge_cnt==P-1:
  - START: strt_glitch_FSM=1 -> IDLE (silent, no pulse); else -> DATA.
  - DATA with bit_cnt==8: -> PARITY if latched PAR_EN, else -> STOP.
  - PARITY: -> STOP.
- STOP exits early at edge_cnt==CHK+1, so the next start edge is not missed:
  - Evaluate stp_err_FSM and (latched PAR_EN & par_err_FSM).
  - No error: data_valid_FSM=1 in the following cycle.
  - Any error: frame_err_FSM=1 in the following cycle.
  - Next state is IDLE in both cases; the exit resets the counters to 0.
- Pulse exclusivity: data_valid_FSM and frame_err_FSM are registered, mutually exclusive, and exactly one cycle wide.
- Back-to-back frames: RX_IN_FSM=0 in the first IDLE cycle (same cycle as the data_valid pulse) enters START normally.
- Invariant: at most one of the check/deser enables is high in any cycle.

Decomposition:
- Package urt_rx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP)
  - prescale legal-value constants (8/16/32)
  - the DATA_BITS=8 constant
  - functions for SAMP/CHK offsets from P
- Sub-module urt_rx_edge_bit_cnt holds the edge/bit counter pair.
  - Inputs: enable, clear, P.
  - Outputs: edge_cnt, bit_cnt, last_edge.
  - The FSM owns all decode.

Test Plan:
- P=8, no parity, byte 0xA5 LSB first, start edge seen in IDLE at cycle t0 -> START at t0+1; 8 deser_en pulses at edge_cnt=6; data_valid_FSM single pulse at t0+81; no frame_err.
- P=8, PAR_EN=1, 0xA5 with parity bit 0 and checker par_err=0 -> par_chk_en one pulse at bit_cnt=9, edge_cnt=6; data_valid at t0+89.
- P=16, PAR_EN=1, par_err_FSM forced 1 after par_chk_en -> frame_err_FSM one pulse, data_valid stays 0, FSM back in IDLE.
- RX low for 2 cycles then high, strt_glitch_FSM=1 at START end -> IDLE after 8 cycles (P=8); no deser_en, no pulses.
- RST_FSM=1 during DATA at bit_cnt=4 -> next cycle state IDLE, counters 0, all outputs 0; no data_valid ever for that frame.
- PRESCALE_FSM=12 at start, changed to 32 mid-frame -> frame timed with P=8 throughout; two back-to-back frames both yield data_valid.
